// File: rtl/jk_ff_cmd_arbiter.sv
// Round-robin arbiter issuing single-cycle J/K pulses from NUM_REQ requesters onto a bank of NUM_FF JK flip-flops.
// Optional macro JK_ARB_SHADOW_EN enables shadow_q, a mirror of the expected bank state.
module jk_ff_cmd_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int NUM_FF     = 8,
   parameter int IDX_W      = 3,
   parameter int GAP_CYCLES = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [2*NUM_REQ-1:0]     req_op,
   input  logic [IDX_W*NUM_REQ-1:0] req_idx,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [NUM_FF-1:0]        j_vec,
   output logic [NUM_FF-1:0]        k_vec,
   output logic                     busy,
   output logic [2:0]               grant_id,
   output logic                     err_oor,
   output logic [15:0]              cmd_count,
   output logic [NUM_FF-1:0]        shadow_q
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

   localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   state_t              state_q;
   logic [2:0]          rr_q;
   logic [3:0]          gap_q;
   logic [NUM_FF-1:0]   j_q;
   logic [NUM_FF-1:0]   k_q;
   logic                busy_q;
   logic [2:0]          grant_q;
   logic                err_q;
   logic [15:0]         cnt_q;

   logic                found_d;
   logic [2:0]          win_d;
   logic [2:0]          rr_d;
   logic [NUM_REQ-1:0]  ready_d;
   logic [1:0]          op_d;
   logic [IDX_W-1:0]    idx_d;
   logic                in_range_d;
   logic [NUM_FF-1:0]   mask_d;
   int                  r;

   // Search starts at rr_q so the most recently served requester goes last
   always_comb begin
      found_d = 1'b0;
      win_d   = '0;
      ready_d = '0;
      op_d    = '0;
      idx_d   = '0;
      r       = 0;
      if (state_q == S_IDLE) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            r = (int'(rr_q) + k) % NUM_REQ;
            if (!found_d && req_valid[r]) begin
               found_d    = 1'b1;
               win_d      = 3'(r);
               ready_d[r] = 1'b1;
               op_d       = req_op[2*r +: 2];
               idx_d      = req_idx[IDX_W*r +: IDX_W];
            end
         end
      end
   end

   always_comb begin
      in_range_d = (int'(idx_d) < NUM_FF);
      mask_d     = in_range_d ? (NUM_FF'(1) << idx_d) : '0;
      rr_d       = (int'(win_d) == NUM_REQ - 1) ? 3'd0 : win_d + 3'd1;
   end

   assign req_ready = ready_d;
   assign j_vec     = j_q;
   assign k_vec     = k_q;
   assign busy      = busy_q;
   assign grant_id  = grant_q;
   assign err_oor   = err_q;
   assign cmd_count = cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         rr_q    <= '0;
         gap_q   <= '0;
         j_q     <= '0;
         k_q     <= '0;
         busy_q  <= 1'b0;
         grant_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (found_d) begin
                  grant_q <= win_d;
                  rr_q    <= rr_d;
                  cnt_q   <= cnt_q + 16'd1;
                  busy_q  <= 1'b1;
                  j_q     <= op_d[1] ? mask_d : '0;
                  k_q     <= op_d[0] ? mask_d : '0;
                  if (!in_range_d) err_q <= 1'b1;
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               j_q <= '0;
               k_q <= '0;
               if (GAP_CYCLES > 0) begin
                  gap_q   <= GAP_LOAD;
                  state_q <= S_GAP;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            S_GAP: begin
               if (gap_q == 4'd0) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  gap_q <= gap_q - 4'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef JK_ARB_SHADOW_EN
   // Updated on the accept edge so it reflects the pulse being driven during ISSUE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= '0;
      end else if (state_q == S_IDLE && found_d) begin
         case (op_d)
            2'b01:   shadow_q <= shadow_q & ~mask_d;
            2'b10:   shadow_q <= shadow_q | mask_d;
            2'b11:   shadow_q <= shadow_q ^ mask_d;
            default: shadow_q <= shadow_q;
         endcase
      end
   end
`else
   assign shadow_q = '0;
`endif

endmodule

// File: tb/tb_jk_ff_cmd_arbiter.sv
// Bench for jk_ff_cmd_arbiter: unit A (NUM_FF=6, GAP_CYCLES=1) and unit B (NUM_FF=8, GAP_CYCLES=0) against a timeline model.
module tb_jk_ff_cmd_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [3:0]  a_valid, a_ready, b_valid, b_ready;
   logic [7:0]  a_op, b_op;
   logic [11:0] a_idx, b_idx;
   logic [5:0]  a_j, a_k, a_sh;
   logic [7:0]  b_j, b_k, b_sh;
   logic        a_busy, b_busy, a_err, b_err;
   logic [2:0]  a_gid, b_gid;
   logic [15:0] a_cnt, b_cnt;

   jk_ff_cmd_arbiter #(.NUM_REQ(4), .NUM_FF(6), .IDX_W(3), .GAP_CYCLES(1)) u_a (
      .clk(clk), .rst(rst), .req_valid(a_valid), .req_op(a_op), .req_idx(a_idx),
      .req_ready(a_ready), .j_vec(a_j), .k_vec(a_k), .busy(a_busy), .grant_id(a_gid),
      .err_oor(a_err), .cmd_count(a_cnt), .shadow_q(a_sh));

   jk_ff_cmd_arbiter #(.NUM_REQ(4), .NUM_FF(8), .IDX_W(3), .GAP_CYCLES(0)) u_b (
      .clk(clk), .rst(rst), .req_valid(b_valid), .req_op(b_op), .req_idx(b_idx),
      .req_ready(b_ready), .j_vec(b_j), .k_vec(b_k), .busy(b_busy), .grant_id(b_gid),
      .err_oor(b_err), .cmd_count(b_cnt), .shadow_q(b_sh));

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Timeline model: an accepted command pulses on the next cycle, keeps busy for
   // 1+GAP cycles, and the arbiter can grant again 2+GAP cycles after acceptance.
   typedef struct {
      int          rr;
      int          pulse_at;
      int          free_at;
      int          gid;
      int          pidx;
      logic [1:0]  pop;
      logic [15:0] cnt;
      logic        err;
      logic [7:0]  sh;
   } mdl_t;

   mdl_t        m[2];
   logic [3:0]  mv[2], ar[2];
   logic [7:0]  mo[2], aj[2], ak[2], ash[2];
   logic [11:0] mi[2];
   logic        ab[2], ae[2];
   logic [2:0]  ag[2];
   logic [15:0] ac[2];
   int          gap_u, nf_u, w, rq;
   logic [3:0]  er;
   logic [7:0]  ej, ek;
   logic        eb;

   always @(negedge clk) begin
      mv[0] = a_valid; mo[0] = a_op; mi[0] = a_idx;
      mv[1] = b_valid; mo[1] = b_op; mi[1] = b_idx;
      ar[0] = a_ready; aj[0] = 8'(a_j); ak[0] = 8'(a_k); ash[0] = 8'(a_sh);
      ab[0] = a_busy;  ae[0] = a_err;   ag[0] = a_gid;   ac[0] = a_cnt;
      ar[1] = b_ready; aj[1] = b_j;     ak[1] = b_k;     ash[1] = b_sh;
      ab[1] = b_busy;  ae[1] = b_err;   ag[1] = b_gid;   ac[1] = b_cnt;
      for (int u = 0; u < 2; u++) begin
         gap_u = (u == 0) ? 1 : 0;
         nf_u  = (u == 0) ? 6 : 8;
         if (rst) begin
            m[u].rr = 0; m[u].pulse_at = -100; m[u].free_at = 0; m[u].gid = 0;
            m[u].pidx = 0; m[u].pop = 2'b00; m[u].cnt = 16'd0; m[u].err = 1'b0; m[u].sh = 8'h00;
         end else begin
            w  = -1;
            er = 4'b0000;
            if (cyc >= m[u].free_at) begin
               for (int q = 0; q < 4; q++) begin
                  rq = (m[u].rr + q) % 4;
                  if (w < 0 && mv[u][rq]) w = rq;
               end
            end
            if (w >= 0) er[w] = 1'b1;
            ej = 8'h00;
            ek = 8'h00;
            if (cyc == m[u].pulse_at && m[u].pidx < nf_u) begin
               ej[m[u].pidx] = m[u].pop[1];
               ek[m[u].pidx] = m[u].pop[0];
            end
            eb = (cyc >= m[u].pulse_at) && (cyc <= m[u].pulse_at + gap_u);
            chk($sformatf("u%0d req_ready", u), 32'(ar[u]), 32'(er));
            chk($sformatf("u%0d j_vec", u), 32'(aj[u]), 32'(ej));
            chk($sformatf("u%0d k_vec", u), 32'(ak[u]), 32'(ek));
            chk($sformatf("u%0d busy", u), 32'(ab[u]), 32'(eb));
            chk($sformatf("u%0d grant_id", u), 32'(ag[u]), 32'(m[u].gid));
            chk($sformatf("u%0d err_oor", u), 32'(ae[u]), 32'(m[u].err));
            chk($sformatf("u%0d cmd_count", u), 32'(ac[u]), 32'(m[u].cnt));
            chk($sformatf("u%0d shadow_q", u), 32'(ash[u]), 32'(m[u].sh));
            if (w >= 0) begin
               m[u].gid      = w;
               m[u].rr       = (w + 1) % 4;
               m[u].cnt      = m[u].cnt + 16'd1;
               m[u].pulse_at = cyc + 1;
               m[u].free_at  = cyc + 2 + gap_u;
               m[u].pop      = mo[u][2*w +: 2];
               m[u].pidx     = int'(mi[u][3*w +: 3]);
               if (m[u].pidx >= nf_u) m[u].err = 1'b1;
`ifdef JK_ARB_SHADOW_EN
               else if (m[u].pop == 2'b01) m[u].sh[m[u].pidx] = 1'b0;
               else if (m[u].pop == 2'b10) m[u].sh[m[u].pidx] = 1'b1;
               else if (m[u].pop == 2'b11) m[u].sh[m[u].pidx] = ~m[u].sh[m[u].pidx];
`endif
            end
         end
      end
      cyc++;
   end

   int          ng;
   int          gw[5];
   int          gt[5];
   int          exp_rr[5] = '{0, 1, 2, 3, 0};
   logic [7:0]  sh_set, sh_tog0;

   initial begin
`ifdef JK_ARB_SHADOW_EN
      sh_set  = 8'h08;
      sh_tog0 = 8'h01;
`else
      sh_set  = 8'h00;
      sh_tog0 = 8'h00;
`endif
      rst = 1'b1;
      a_valid = '0; a_op = '0; a_idx = '0;
      b_valid = '0; b_op = '0; b_idx = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("reset ready", 32'(a_ready), 32'h0);
      chk("reset cmd_count", 32'(a_cnt), 32'h0);
      chk("reset busy", 32'(a_busy), 32'h0);

      // Single set command on req0, idx 5
      a_valid = 4'b0001; a_op[1:0] = 2'b10; a_idx[2:0] = 3'd5;
      #1 chk("single ready", 32'(a_ready), 32'h1);
      tick(); a_valid = '0;
      #1;
      chk("single j", 32'(a_j), 32'h20);
      chk("single k", 32'(a_k), 32'h00);
      chk("single busy issue", 32'(a_busy), 32'h1);
      tick(); #1;
      chk("single j gap", 32'(a_j), 32'h00);
      chk("single busy gap", 32'(a_busy), 32'h1);
      tick(); #1;
      chk("single idle busy", 32'(a_busy), 32'h0);
      chk("single cmd_count", 32'(a_cnt), 32'h1);

      // Out-of-range reset command on req1, idx 7 with NUM_FF=6
      a_valid = 4'b0010; a_op[3:2] = 2'b01; a_idx[5:3] = 3'd7;
      #1 chk("oor ready", 32'(a_ready), 32'h2);
      tick(); a_valid = '0;
      #1;
      chk("oor j", 32'(a_j), 32'h00);
      chk("oor k", 32'(a_k), 32'h00);
      chk("oor err", 32'(a_err), 32'h1);
      chk("oor cmd_count", 32'(a_cnt), 32'h2);
      tick(); tick(); #1;
      chk("oor err sticky", 32'(a_err), 32'h1);
      chk("oor grant_id", 32'(a_gid), 32'h1);

      // Reset asserted in the middle of GAP
      a_valid = 4'b0100; a_op[5:4] = 2'b10; a_idx[8:6] = 3'd2;
      tick(); a_valid = '0;
      #1 chk("pre-reset j", 32'(a_j), 32'h04);
      tick();
      #1 rst = 1'b1;
      #1;
      chk("midgap rst busy", 32'(a_busy), 32'h0);
      chk("midgap rst j", 32'(a_j), 32'h0);
      chk("midgap rst k", 32'(a_k), 32'h0);
      chk("midgap rst cmd_count", 32'(a_cnt), 32'h0);
      chk("midgap rst err", 32'(a_err), 32'h0);
      tick(); rst = 1'b0;
      #1 chk("post-reset ready", 32'(a_ready), 32'h0);

      // All four requesters continuously valid with toggle
      a_op = 8'hFF; a_idx = {3'd3, 3'd2, 3'd1, 3'd0}; a_valid = 4'hF;
      ng = 0;
      for (int t = 0; t < 40 && ng < 5; t++) begin
         #1;
         if (a_ready != 4'h0) begin
            for (int q = 0; q < 4; q++) if (a_ready[q]) gw[ng] = q;
            gt[ng] = t;
            ng++;
         end
         tick();
      end
      a_valid = '0;
      chk("rr grant count", 32'(ng), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < ng) begin
            chk($sformatf("rr winner %0d", i), 32'(gw[i]), 32'(exp_rr[i]));
            if (i > 0) chk($sformatf("rr spacing %0d", i), 32'(gt[i] - gt[i-1]), 32'd3);
         end
      end
      repeat (4) tick();

      // Hold op on unit B (GAP_CYCLES=0), req2 kept valid
      b_valid = 4'b0100; b_op[5:4] = 2'b00; b_idx[8:6] = 3'd1;
      #1 chk("hold ready", 32'(b_ready), 32'h4);
      tick(); #1;
      chk("hold j", 32'(b_j), 32'h0);
      chk("hold k", 32'(b_k), 32'h0);
      chk("hold busy", 32'(b_busy), 32'h1);
      chk("hold ready issue", 32'(b_ready), 32'h0);
      chk("hold cmd_count", 32'(b_cnt), 32'h1);
      tick(); #1;
      chk("hold regrant ready", 32'(b_ready), 32'h4);
      b_valid = '0;
      tick(); #1;
      chk("hold withdrawn count", 32'(b_cnt), 32'h1);
      chk("hold withdrawn busy", 32'(b_busy), 32'h0);

      // Shadow sequence on unit B: set 3, toggle 3, toggle 0
      b_valid = 4'b0001; b_op[1:0] = 2'b10; b_idx[2:0] = 3'd3;
      tick(); b_valid = '0;
      #1;
      chk("shadow set j", 32'(b_j), 32'h08);
      chk("shadow set sh", 32'(b_sh), 32'(sh_set));
      tick();
      b_valid = 4'b0001; b_op[1:0] = 2'b11; b_idx[2:0] = 3'd3;
      tick(); b_valid = '0;
      #1;
      chk("shadow tog3 j", 32'(b_j), 32'h08);
      chk("shadow tog3 k", 32'(b_k), 32'h08);
      chk("shadow tog3 sh", 32'(b_sh), 32'h00);
      tick();
      b_valid = 4'b0001; b_op[1:0] = 2'b11; b_idx[2:0] = 3'd0;
      tick(); b_valid = '0;
      #1;
      chk("shadow tog0 j", 32'(b_j), 32'h01);
      chk("shadow tog0 sh", 32'(b_sh), 32'(sh_tog0));
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
